logic_op_arbiter: RTL and testbench
===================================

LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters (2..8).
REQ-002 Parameter W, default 8, operand/result width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  N  per-requester request valid.
REQ-006 req_ready  output  N  per-requester accept; one-hot or zero.
REQ-007 req_op  input  3*N  op code of requester i in bits [3i+2:3i].
REQ-008 req_a  input  W*N  operand A of requester i in bits [W*i+W-1:W*i].
REQ-009 req_b  input  W*N  operand B of requester i, same packing.
REQ-010 resp_valid  output  1  result register holds a valid result.
REQ-011 resp_ready  input  1  consumer accepts result.
REQ-012 resp_id  output  clog2(N)  index of the requester that produced the result.
REQ-013 resp_data  output  W  bitwise result.
REQ-014 resp_err  output  1  illegal op code flag for this result.

Function
REQ-015 Op codes, bitwise on W bits: 0 AND, 1 OR, 2 NOT(A) (B ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal.
REQ-016 Illegal op: the block accepts the request, sets resp_data 0 and resp_err 1; resp_err is 0 for all legal ops.
REQ-017 Slot free = !resp_valid || resp_ready; grant only when slot free and at least one req_valid bit is set.
REQ-018 Arbitration: round-robin; search starts at pointer p and wraps modulo N; first requester with req_valid=1 wins.
REQ-019 req_ready[g]=1 combinationally for the winner g only; the transfer occurs when req_valid[g] && req_ready[g].
REQ-020 After a transfer, p = (g+1) mod N; without a transfer, p holds.
REQ-021 Latency: request accepted at edge t produces resp_valid=1 with result, id and err registered at edge t, visible in cycle t+1.
REQ-022 resp_* outputs hold stable while resp_valid && !resp_ready.
REQ-023 Simultaneous drain and grant in one cycle: new result loads, resp_valid stays 1, giving 1 result/cycle throughput.
REQ-024 Drain with no grant: resp_valid clears at that edge.
REQ-025 Requester obligation: once req_valid is raised, op/a/b stay stable until accepted; the block does not check this.
REQ-026 Fairness: a requester holding req_valid is granted within N transfers.
REQ-027 req_valid deasserted before grant: the request is dropped, no response.

Reset
REQ-028 On rst=1 at an edge: resp_valid=0, resp_data=0, resp_id=0, resp_err=0, p=0.
REQ-029 req_ready is 0 throughout any cycle with rst=1.
REQ-030 Reset mid-operation discards any held result; no response is emitted for it.

Structure
REQ-031 Shared package logic_op_pkg holds the 3-bit op-code constants (OP_AND..OP_XNOR, OP_ILL) and the op-code width.
REQ-032 Sub-module logic_unit: combinational, W-bit, maps op/a/b to data/err using the basic two-input gate functions.
REQ-033 The top instantiates exactly one logic_unit, shared by all requesters through the grant mux.
REQ-034 Arbiter pointer, result register and handshake logic reside in the top.

Verification
REQ-035 Single requester: req 2 op=0 (AND), a=8'hF0, b=8'h3C, resp_ready=1 -> next cycle resp_valid=1, id=2, data=8'h30, err=0.
REQ-036 All ops: op codes 1..6 with a=8'hAA, b=8'h0F -> data 8'hAF, 8'h55, 8'hF5, 8'h50, 8'hA5, 8'h5A; op 7 -> data 8'h00, err=1.
REQ-037 Fairness, N=4, all valid, resp_ready=1, p=0 -> grants 0,1,2,3,0 on consecutive cycles, one response per cycle.
REQ-038 Backpressure: resp_ready=0 with result held -> req_ready=0, resp_* unchanged for 5 cycles; resp_ready=1 -> drain and new grant in the same cycle.
REQ-039 Reset mid-flight: rst=1 while resp_valid=1 -> next cycle resp_valid=0, p=0, and the next grant goes to the lowest valid index.
REQ-040 Wrap: p=3, req_valid=4'b0101 -> requester 0 granted, then p=1; next grant is requester 2.

Source files
------------

// File: rtl/logic_op_pkg.sv
// Op-code encoding for the logic_op_arbiter datapath.
// Shared by the logic unit and the arbiter top.
package logic_op_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_NOT  = 3'd2;
  localparam op_t OP_NAND = 3'd3;
  localparam op_t OP_NOR  = 3'd4;
  localparam op_t OP_XOR  = 3'd5;
  localparam op_t OP_XNOR = 3'd6;
  localparam op_t OP_ILL  = 3'd7;

endpackage

// File: rtl/logic_unit.sv
// Combinational W-bit bitwise unit: maps op/a/b to a result and an illegal-op flag.
module logic_unit
  import logic_op_pkg::*;
#(
  parameter int W = 8
) (
  input  op_t          op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] data_o,
  output logic         err_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves a latch.
    data_o = '0;
    err_o  = 1'b0;
    case (op_i)
      OP_AND:  data_o = a_i & b_i;
      OP_OR:   data_o = a_i | b_i;
      OP_NOT:  data_o = ~a_i;
      OP_NAND: data_o = ~(a_i & b_i);
      OP_NOR:  data_o = ~(a_i | b_i);
      OP_XOR:  data_o = a_i ^ b_i;
      OP_XNOR: data_o = ~(a_i ^ b_i);
      default: err_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter feeding N requesters through one shared logic unit into
// a single registered result slot with valid/ready handshake.
module logic_op_arbiter
  import logic_op_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid,
  output logic [N-1:0]           req_ready,
  input  logic [OP_W*N-1:0]      req_op,
  input  logic [W*N-1:0]         req_a,
  input  logic [W*N-1:0]         req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [$clog2(N)-1:0]   resp_id,
  output logic [W-1:0]           resp_data,
  output logic                   resp_err
);

  localparam int            IW    = $clog2(N);
  localparam logic [IW:0]   N_EXT = (IW+1)'(N);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);

  logic [IW-1:0] p_q, p_d;
  logic          resp_valid_q, resp_valid_d;
  logic [IW-1:0] resp_id_q, resp_id_d;
  logic [W-1:0]  resp_data_q, resp_data_d;
  logic          resp_err_q, resp_err_d;

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] dbl_shift;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;
  logic [IW-1:0]  win;
  logic           found;
  logic           slot_free;
  logic           grant;

  op_t           sel_op;
  logic [W-1:0]  sel_a, sel_b;
  logic [W-1:0]  lu_data;
  logic          lu_err;

  // Rotate the valid vector so bit 0 is the pointer position, pick the first
  // set bit, then rotate the offset back to an absolute requester index.
  always_comb begin
    dbl       = {req_valid, req_valid};
    dbl_shift = dbl >> p_q;
    rot       = dbl_shift[N-1:0];
    found     = 1'b0;
    off       = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = IW'(k);
      end
    end
    sum = {1'b0, p_q} + {1'b0, off};
    win = (sum >= N_EXT) ? IW'(sum - N_EXT) : sum[IW-1:0];
  end

  assign slot_free = !resp_valid_q || resp_ready;
  assign grant     = found && slot_free && !rst;
  assign req_ready = grant ? (N'(1) << win) : '0;

  assign sel_op = req_op[win*OP_W +: OP_W];
  assign sel_a  = req_a[win*W +: W];
  assign sel_b  = req_b[win*W +: W];

  logic_unit #(.W(W)) u_logic_unit (
    .op_i   (sel_op),
    .a_i    (sel_a),
    .b_i    (sel_b),
    .data_o (lu_data),
    .err_o  (lu_err)
  );

  // A grant overrides a drain so the slot can turn over every cycle.
  always_comb begin
    p_d          = p_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    if (grant) begin
      resp_valid_d = 1'b1;
      resp_id_d    = win;
      resp_data_d  = lu_data;
      resp_err_d   = lu_err;
      p_d          = (win == LAST) ? '0 : win + 1'b1;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      p_q          <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      p_q          <= p_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: a cycle-level reference model is
// compared every cycle, and directed scenarios pin it with literal values.
module tb_logic_op_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [3*N-1:0]    req_op;
  logic [W*N-1:0]    req_a;
  logic [W*N-1:0]    req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [IW-1:0]     resp_id;
  logic [W-1:0]      resp_data;
  logic              resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_p;
  bit          m_v;
  int          m_id;
  logic [7:0]  m_data;
  bit          m_err;
  int          last_g;

  always #5 clk = ~clk;

  logic_op_arbiter #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_eval(input int op, input logic [7:0] a, input logic [7:0] b,
                                   output logic [7:0] d, output bit e);
    e = 1'b0;
    case (op)
      0: d = a & b;
      1: d = a | b;
      2: d = ~a;
      3: d = ~(a & b);
      4: d = ~(a | b);
      5: d = a ^ b;
      6: d = ~(a ^ b);
      default: begin d = 8'h00; e = 1'b1; end
    endcase
  endfunction

  function automatic int ref_winner();
    if (rst) return -1;
    if (m_v && !resp_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_p + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input int op, input logic [7:0] a, input logic [7:0] b);
    req_op[3*i +: 3] = op[2:0];
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
  endtask

  // One clock cycle: compare DUT against the model, advance both across the edge.
  task automatic step();
    int          g;
    logic [N-1:0] exp_ready;
    logic [7:0]  d;
    bit          e;
    #1;
    g = ref_winner();
    exp_ready = (g < 0) ? '0 : (N'(1) << g);
    check("req_ready", req_ready, exp_ready);
    check("resp_valid", resp_valid, m_v);
    if (m_v) begin
      check("resp_id", resp_id, m_id);
      check("resp_data", resp_data, m_data);
      check("resp_err", resp_err, m_err);
    end
    @(posedge clk);
    last_g = g;
    if (rst) begin
      m_v = 0; m_p = 0; m_id = 0; m_data = 8'h00; m_err = 0;
    end else if (g >= 0) begin
      ref_eval(int'(req_op[3*g +: 3]), req_a[W*g +: W], req_b[W*g +: W], d, e);
      m_v = 1; m_id = g; m_data = d; m_err = e;
      m_p = (g + 1) % N;
    end else if (resp_ready) begin
      m_v = 0;
    end
    @(negedge clk);
  endtask

  logic [7:0] exp_tbl [1:7];

  initial begin
    exp_tbl[1] = 8'hAF; exp_tbl[2] = 8'h55; exp_tbl[3] = 8'hF5; exp_tbl[4] = 8'h50;
    exp_tbl[5] = 8'hA5; exp_tbl[6] = 8'h5A; exp_tbl[7] = 8'h00;

    m_p = 0; m_v = 0; m_id = 0; m_data = 0; m_err = 0; last_g = -1;
    rst = 1'b1; req_valid = '1; resp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    @(negedge clk);

    // Reset holds off grants even with every requester valid.
    step();
    step();
    check("rst_valid", resp_valid, 0);
    check("rst_id",    resp_id,    0);
    check("rst_data",  resp_data,  0);
    check("rst_err",   resp_err,   0);
    check("rst_ready", req_ready,  0);

    rst = 1'b0; req_valid = '0; resp_ready = 1'b1;
    step();

    // Single requester AND
    set_req(2, 0, 8'hF0, 8'h3C);
    req_valid = 4'b0100;
    step();
    check("single_grant", last_g, 2);
    check("single_valid", resp_valid, 1);
    check("single_id",    resp_id,    2);
    check("single_data",  resp_data,  8'h30);
    check("single_err",   resp_err,   0);
    req_valid = '0;

    // All op codes through requester 1
    for (int op = 1; op <= 7; op++) begin
      set_req(1, op, 8'hAA, 8'h0F);
      req_valid = 4'b0010;
      step();
      check($sformatf("op%0d_data", op), resp_data, exp_tbl[op]);
      check($sformatf("op%0d_err", op),  resp_err,  (op == 7) ? 1 : 0);
    end
    req_valid = '0;
    step();
    check("drain_valid", resp_valid, 0);

    // Fairness from p=0 with everyone requesting
    rst = 1'b1; step(); rst = 1'b0;
    set_req(0, 1, 8'hAA, 8'h0F);
    set_req(1, 2, 8'hAA, 8'h0F);
    set_req(2, 5, 8'hAA, 8'h0F);
    set_req(3, 7, 8'hAA, 8'h0F);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rr_grant%0d", i), last_g, i % N);
      check($sformatf("rr_id%0d", i), resp_id, i % N);
      check($sformatf("rr_valid%0d", i), resp_valid, 1);
    end

    // Backpressure: result from requester 0 (OR -> AF) must hold
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_ready", req_ready, 0);
      check("bp_id",    resp_id,   0);
      check("bp_data",  resp_data, 8'hAF);
      check("bp_valid", resp_valid, 1);
    end
    resp_ready = 1'b1;
    step();
    check("bp_release_grant", last_g, 1);
    check("bp_release_id",    resp_id, 1);
    check("bp_release_data",  resp_data, 8'h55);

    // Reset mid-flight discards the held result and clears the pointer
    rst = 1'b1;
    step();
    check("mid_rst_valid", resp_valid, 0);
    rst = 1'b0;
    req_valid = 4'b1010;
    step();
    check("post_rst_grant", last_g, 1);

    // Wrap: move pointer to 3, then 0101 picks 0 then 2
    req_valid = 4'b0100;
    step();
    check("wrap_setup", last_g, 2);
    req_valid = 4'b0101;
    step();
    check("wrap_grant0", last_g, 0);
    step();
    check("wrap_grant2", last_g, 2);
    check("wrap_id2", resp_id, 2);

    // Mixed traffic and backpressure, model-checked every cycle
    for (int i = 0; i < 60; i++) begin
      for (int r = 0; r < N; r++)
        set_req(r, int'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      req_valid  = N'($urandom);
      resp_ready = 1'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
